// File: rtl/ser_queue_pkg.sv
// Shared defaults and sizing helpers for the serial-in, queued-word-out subsystem.
// Pure constants and functions; no logic, no latency, no flow control.
package ser_queue_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int DES_DIV_DEF = 10;
    localparam int Q_DIV_DEF   = 100;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Single-cycle enable pulse every DIV clocks; first pulse DIV-1 cycles after reset.
// Free-running, combinational pulse from a registered counter; no backpressure.
module tick_gen
    import ser_queue_pkg::*;
#(
    parameter int DIV = DES_DIV_DEF
) (
    input  logic clock_1MHz,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ser_queue_subsystem.sv
// Serial MSB-first deserializer feeding a DEPTH-entry circular queue; all outputs registered, one cycle after the qualifying tick.
// A completed word is held (serial bits dropped) until the queue accepts it; full queue accepts only alongside a dequeue.
module ser_queue_subsystem
    import ser_queue_pkg::*;
#(
    parameter int  WIDTH   = WIDTH_DEF,
    parameter int  DEPTH   = DEPTH_DEF,
    parameter int  DES_DIV = DES_DIV_DEF,
    parameter int  Q_DIV   = Q_DIV_DEF,
    localparam int LW      = len_width(DEPTH)
) (
    input  logic             clock_1MHz,
    input  logic             rst,
    input  logic             data_in,
    input  logic             write_in,
    input  logic             dequeue_in,
    output logic             status_out,
    output logic [WIDTH-1:0] data_out,
    output logic [LW-1:0]    len_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(WIDTH);

    logic des_tick;
    logic q_tick;

    tick_gen #(.DIV(DES_DIV)) u_des_tick (.clock_1MHz, .rst, .tick(des_tick));
    tick_gen #(.DIV(Q_DIV))   u_q_tick   (.clock_1MHz, .rst, .tick(q_tick));

    // Only the WIDTH-1 earlier bits need storing; the newest comes straight from data_in.
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] hold_q;
    logic [BW-1:0]    bit_cnt;
    logic             bit_acc;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [LW-1:0]    len_nxt;
    logic             deq;
    logic             enq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bit_acc   = des_tick && write_in && !status_out;
    assign shift_nxt = {shift_q, data_in};
    assign deq       = q_tick && dequeue_in && !empty_out;
    // enq doubles as the hand-off acknowledge: it fires only on an actual write.
    assign enq       = q_tick && status_out && (!full_out || deq);

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            shift_q    <= '0;
            hold_q     <= '0;
            bit_cnt    <= '0;
            status_out <= 1'b0;
        end else begin
            if (bit_acc) begin
                shift_q <= shift_nxt[WIDTH-2:0];
                if (bit_cnt == BW'(WIDTH - 1)) begin
                    hold_q     <= shift_nxt;
                    status_out <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end
            if (enq) begin
                status_out <= 1'b0;
            end
        end
    end

    always_comb begin
        len_nxt = len_out;
        case ({enq, deq})
            2'b10:   len_nxt = len_out + LW'(1);
            2'b01:   len_nxt = len_out - LW'(1);
            default: len_nxt = len_out;
        endcase
    end

    // Storage is not reset; entries are only readable once written.
    always_ff @(posedge clock_1MHz) begin
        if (enq) begin
            mem[tail] <= hold_q;
        end
    end

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            data_out  <= '0;
            len_out   <= '0;
            full_out  <= 1'b0;
            empty_out <= 1'b1;
        end else begin
            if (enq) begin
                tail <= ptr_inc(tail);
            end
            if (deq) begin
                data_out <= mem[head];
                head     <= ptr_inc(head);
            end
            len_out   <= len_nxt;
            full_out  <= (len_nxt == LW'(DEPTH));
            empty_out <= (len_nxt == '0);
        end
    end

endmodule
